// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues single-outstanding word fetches over req/gnt/rvalid,
// and presents InstrFD/PCF_curr/PCPlus4FD to the F/D register. Optional: FETCH_MISALIGN_TRAP_EN.
//
// state  | meaning
// S_REQ  | request at PCF is driven (unless parked on a misaligned redirect)
// S_WAIT | one request granted, waiting for its response (stale = response is discarded)
// S_HOLD | response captured in buf_instr while decode is stalled
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        FetchMisalignF,
`endif
   output logic [31:0] InstrFD,
   output logic [31:0] PCF_curr,
   output logic [31:0] PCPlus4FD,
   output logic        FetchValidF,
   output logic        FetchBusyF
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic        stale_q, stale_d;
   logic        lost_rsp_q, lost_rsp_d;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        parked;
   logic        granted;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign target         = PCTargetE;
   assign parked         = misalign_q;
   assign FetchMisalignF = misalign_q;

   always_comb begin
      misalign_d = misalign_q;
      if (PCSrcE) misalign_d = (PCTargetE[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end
`else
   logic unused_tgt_lsbs;

   assign unused_tgt_lsbs = ^PCTargetE[1:0];
   assign target          = {PCTargetE[31:2], 2'b00};
   assign parked          = 1'b0;
`endif

   assign pc_plus4   = pcf_q + 32'd4;
   assign granted    = imem_req & imem_gnt;
   assign PCPlus4FD  = pc_plus4;
   assign FetchBusyF = ~FetchValidF;

   always_comb begin
      state_d     = state_q;
      pcf_d       = pcf_q;
      stale_d     = stale_q;
      buf_instr_d = buf_instr_q;
      imem_req    = 1'b0;
      imem_addr   = pcf_q;
      InstrFD     = NOP_INSTR;
      PCF_curr    = pcf_q;
      FetchValidF = 1'b0;
      if (!rst) begin
         case (state_q)
            S_REQ: begin
               imem_req = ~parked;
               if (PCSrcE) pcf_d = target;
               if (granted) begin
                  state_d = S_WAIT;
                  stale_d = PCSrcE;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_d = S_REQ;
                  stale_d = 1'b0;
                  if (PCSrcE) begin
                     pcf_d = target;
                  end else if (!stale_q) begin
                     InstrFD     = imem_rdata;
                     FetchValidF = 1'b1;
                     if (StallF) begin
                        buf_instr_d = imem_rdata;
                        state_d     = S_HOLD;
                     end else begin
                        pcf_d = pc_plus4;
                     end
                  end
               end else if (PCSrcE) begin
                  // response still in flight; mark it so it is dropped on arrival
                  stale_d = 1'b1;
                  pcf_d   = target;
               end
            end
            S_HOLD: begin
               InstrFD     = buf_instr_q;
               FetchValidF = 1'b1;
               if (PCSrcE) begin
                  pcf_d   = target;
                  state_d = S_REQ;
               end else if (!StallF) begin
                  pcf_d   = pc_plus4;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   // a response pending across reset may still arrive; it is ignored in S_REQ
   always_comb begin
      lost_rsp_d = lost_rsp_q;
      if (imem_rvalid || granted) lost_rsp_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pcf_q       <= RESET_PC;
         stale_q     <= 1'b0;
         buf_instr_q <= NOP_INSTR;
         lost_rsp_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         pcf_q       <= pcf_d;
         stale_q     <= stale_d;
         buf_instr_q <= buf_instr_d;
         lost_rsp_q  <= lost_rsp_d;
      end
   end

   a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> ((state_q == S_WAIT) || lost_rsp_q));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage directly upstream of the fetch/decode pipeline register.
- Owns the program counter and issues word fetches over a req/gnt/rvalid instruction-memory handshake.
- Handles branch/jump redirects from Execute and stalls from the hazard unit.
- Each cycle drives InstrFD, PCF_curr and PCPlus4FD, which the F/D register captures when not stalled. When no instruction is ready, it drives a NOP bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid fetch is available (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  hazard unit: decode cannot accept; hold the current fetch result.
- PCSrcE  input  1  Execute redirect (taken branch/jump).
- PCTargetE  input  32  redirect target address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (word aligned).
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  fetched instruction.
- InstrFD  output  32  instruction to the F/D register.
- PCF_curr  output  32  PC of InstrFD.
- PCPlus4FD  output  32  PCF_curr + 4.
- FetchValidF  output  1  InstrFD holds a real instruction.
- FetchBusyF  output  1  equals !FetchValidF; hazard unit inserts a bubble into Decode.

Behaviour:
- Registered state:
  - PCF, 32 bits.
  - state in {REQ, WAIT, HOLD}.
  - stale flag.
  - 32-bit buffer buf_instr.
- At most one outstanding request.
- Reset: PCF=RESET_PC, state=REQ, stale=0, buf_instr=NOP_INSTR. imem_req=0 while rst=1.
- Reset output values (combinational, reset state):
  - InstrFD=NOP_INSTR
  - PCF_curr=RESET_PC, PCPlus4FD=RESET_PC+4
  - FetchValidF=0, FetchBusyF=1
- Outputs are combinational from state and response; there is no added latency beyond memory latency.
- Arithmetic: PC+4 is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- REQ:
  - imem_req=1, imem_addr=PCF.
  - gnt=1 and PCSrcE=0: go to WAIT.
  - gnt=1 and PCSrcE=1: the accepted request is stale. PCF<=PCSrcE target, stale<=1, go to WAIT.
  - gnt=0 and PCSrcE=1: PCF<=PCTargetE, stay in REQ. The address changes only while ungranted.
- WAIT:
  - imem_req=0.
  - rvalid=1 and stale=1: discard the data, stale<=0, go to REQ.
  - rvalid=1, stale=0, PCSrcE=1: discard the data, PCF<=PCTargetE, go to REQ.
  - rvalid=1, stale=0, PCSrcE=0, StallF=0:
    - InstrFD=imem_rdata, PCF_curr=PCF, FetchValidF=1 this cycle.
    - PCF<=PCF+4, go to REQ.
  - rvalid=1, stale=0, PCSrcE=0, StallF=1: output imem_rdata with FetchValidF=1, buf_instr<=imem_rdata, go to HOLD.
  - rvalid=0 and PCSrcE=1: stale<=1, PCF<=PCTargetE.
- HOLD:
  - InstrFD=buf_instr, PCF_curr=PCF, FetchValidF=1.
  - PCSrcE=1: drop the buffer, PCF<=PCTargetE, go to REQ. PCSrcE has priority over StallF.
  - StallF=0: PCF<=PCF+4, go to REQ.
  - Otherwise remain in HOLD, with outputs stable.
- Outside a valid cycle: InstrFD=NOP_INSTR, PCF_curr=PCF, FetchValidF=0.
- Throughput: one instruction per 2 cycles at zero-wait memory (REQ then WAIT).
- rvalid in REQ or HOLD is a protocol violation. It is ignored; an assertion fires in simulation.
- Reset mid-WAIT: the pending response is lost. After rst deasserts, any rvalid in REQ is ignored and the fetch restarts at RESET_PC.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output FetchMisalignF (1 bit), registered and reset to 0.
  - A redirect with PCTargetE[1:0]!=0 sets FetchMisalignF=1. PCF<=PCTargetE, then the block parks in REQ with imem_req=0 and FetchValidF=0.
  - It stays parked until rst or a redirect with an aligned target, which clears the flag.
- Undefined:
  - No port.
  - PCTargetE[1:0] is ignored: PCF<={PCTargetE[31:2],2'b00}.

Test Plan:
- Reset, then release with gnt=1 always and rvalid the cycle after each grant, rdata=0x11,0x22,0x33 -> imem_addr 0x0,0x4,0x8. FetchValidF pulses every 2nd cycle with PCF_curr 0x0,0x4,0x8 and PCPlus4FD 0x4,0x8,0xC.
- StallF=1 for 3 cycles at the rvalid of 0x22 -> InstrFD=0x22, PCF_curr=0x4 held for 4 cycles, no imem_req. Next imem_addr=0x8.
- PCSrcE=1, PCTargetE=0x100 in WAIT, rvalid next cycle with rdata=0xBAD -> 0xBAD never appears with FetchValidF=1. Next imem_addr=0x100.
- PCSrcE=1 in the same cycle as gnt at PCF=0x8, target 0x200 -> the 0x8 response is discarded. The following request is at 0x200.
- PCSrcE=1 (target 0x40) together with StallF=1 in HOLD -> the buffer is dropped and the next imem_addr is 0x40.
- rst=1 asserted in WAIT, rvalid arrives the cycle after release -> ignored. imem_addr=RESET_PC and outputs are NOP with FetchValidF=0.
- With FETCH_MISALIGN_TRAP_EN defined, PCTargetE=0x102 -> FetchMisalignF=1 and no request. A subsequent redirect to 0x104 clears the flag and fetches from 0x104.
